pe_feeder: RTL and testbench
============================

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the maximum number of ifmap/filter pairs per dot-product job (range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports ld_valid (in, 1), ld_ready (out, 1), ld_ifmap (in, 16), ld_filter (in, 16), ld_last (in, 1), ld_bias (in, 16): the load channel; one pair is accepted per cycle when ld_valid&&ld_ready.
REQ-005 SHALL have ports pe_en (out, 1), pe_ifmap (out, 16), pe_filter (out, 16), pe_psum (out, 16): these drive the PE's en, input_ifmap, input_filter and input_psum.
REQ-006 SHALL have port pe_out_psum, input, 16 bits: the PE's registered output_psum, with 1-cycle latency from pe_en.
REQ-007 SHALL have ports res_valid (out, 1), res_ready (in, 1), res_data (out, 16), res_count (out, clog2(DEPTH+1)): the result channel.
REQ-008 SHALL have port flush, input, 1 bit: a synchronous job abort.

Function
REQ-009 SHALL implement FSM states LOAD, RUN, DRAIN, DONE.
REQ-010 LOAD: ld_ready=1. Each handshake writes the pair into buffer[cnt] and increments cnt.
REQ-011 LOAD -> RUN on a handshake with ld_last=1, or on the handshake that makes cnt==DEPTH (forced last). ld_bias SHALL be sampled into bias_q on that handshake only.
REQ-012 RUN: pe_en=1 for exactly cnt consecutive cycles. idx runs 0..cnt-1. pe_ifmap/pe_filter = buffer[idx].
REQ-013 RUN: pe_psum = bias_q when idx==0, else pe_psum = pe_out_psum (combinational feedback, chaining the running sum).
REQ-014 RUN -> DRAIN after the cycle with idx==cnt-1. DRAIN lasts 1 cycle with pe_en=0. At the end of DRAIN, res_data <= pe_out_psum and res_count <= cnt.
REQ-015 DONE: res_valid=1. res_data and res_count SHALL be held stable until res_valid&&res_ready. On that handshake: cnt<=0, state<=LOAD.
REQ-016 Latency: last-pair accept at edge E. res_valid SHALL be high from cycle E+N+2, where N=cnt.
REQ-017 Outside RUN: pe_en=0 and pe_ifmap=pe_filter=pe_psum=0.
REQ-018 Arithmetic: sums and products SHALL wrap modulo 2^16, matching the PE's lower-16-bit accumulate. The feeder SHALL perform no saturation.
REQ-019 ld_ready SHALL be 0 in RUN, DRAIN and DONE. ld_valid in those states SHALL be ignored and have no side effects.
REQ-020 flush=1 in any state SHALL, at the next edge, set state=LOAD, cnt=0, pe_en=0, res_valid=0. flush SHALL take priority over a simultaneous ld or res handshake, and the pair presented with it SHALL be discarded.
REQ-021 In LOAD, a ld_last handshake when cnt==0 SHALL form a 1-pair job. Zero-pair jobs SHALL NOT exist.
REQ-022 Buffer contents SHALL NOT require clearing. Only indices < cnt SHALL be read.

Reset
REQ-023 rst=1 SHALL force state=LOAD, cnt=0, idx=0, bias_q=0, res_data=0, res_count=0 at the next edge.
REQ-024 During and after reset: ld_ready=1 (in LOAD), pe_en=0, res_valid=0.
REQ-025 rst asserted mid-RUN or mid-DONE SHALL abandon the job. No result SHALL be emitted.
REQ-026 rst SHALL have priority over flush and over all handshakes.

Verification
REQ-027 Scenario, basic job: pairs (2,3),(4,5),(1,7), ld_last on the third pair, bias=10, accepted at edge E, PE model attached -> pe_en high for exactly 3 cycles, res_valid at E+5, res_data=43, res_count=3.
REQ-028 Scenario, wrap-around: one pair (0x0100,0x0100), bias=0x0005 -> res_data=0x0005, res_count=1.
REQ-029 Scenario, overflow: DEPTH=16 pairs of (1,1) with ld_last never asserted, bias=0 -> ld_ready drops after the 16th accept, res_data=16, res_count=16.
REQ-030 Scenario, backpressure: res_ready held 0 for 10 cycles in DONE -> res_valid, res_data and res_count stable. ld_ready=0 throughout. On res_ready=1, one handshake, then ld_ready=1 the next cycle.
REQ-031 Scenario, abort: rst (or flush) in the 2nd RUN cycle of a 4-pair job -> pe_en=0 next cycle, no res_valid. A following job (3,3), bias=1 -> res_data=10.
REQ-032 Scenario, simultaneous flush and ld_last handshake in LOAD -> the pair is discarded, cnt=0, state stays LOAD.

Source files
------------

// File: rtl/pe_feeder.sv
// Operand feeder for a single accumulate PE. Buffers ifmap/filter pairs, streams them
// through the PE with psum feedback, then presents the dot product on a result channel.
//
// state | meaning
// LOAD  | accepting pairs into the buffer
// RUN   | streaming buffer[0..cnt-1] into the PE, one pair per cycle
// DRAIN | waiting one cycle for the PE's registered psum
// DONE  | holding the result until res_ready

module pe_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [15:0]                    ld_ifmap,
    input  logic [15:0]                    ld_filter,
    input  logic                           ld_last,
    input  logic [15:0]                    ld_bias,
    output logic                           pe_en,
    output logic [15:0]                    pe_ifmap,
    output logic [15:0]                    pe_filter,
    output logic [15:0]                    pe_psum,
    input  logic [15:0]                    pe_out_psum,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [15:0]                    res_data,
    output logic [$clog2(DEPTH+1)-1:0]     res_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [15:0]     bias_q;
    logic [15:0]     ifmap_buf  [DEPTH];
    logic [15:0]     filter_buf [DEPTH];
    logic            ld_hs;
    logic            last_hs;
    logic            run_end;

    assign ld_hs   = ld_valid && ld_ready;
    // The pair that fills the buffer ends the job even without ld_last.
    assign last_hs = ld_hs && (ld_last || (cnt == CW'(DEPTH - 1)));
    assign run_end = (CW'(idx) == cnt - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        pe_en      = 1'b0;
        pe_ifmap   = 16'h0;
        pe_filter  = 16'h0;
        pe_psum    = 16'h0;
        res_valid  = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                if (last_hs) state_next = RUN;
            end
            RUN: begin
                pe_en     = 1'b1;
                pe_ifmap  = ifmap_buf[idx];
                pe_filter = filter_buf[idx];
                pe_psum   = (idx == '0) ? bias_q : pe_out_psum;
                if (run_end) state_next = DRAIN;
            end
            DRAIN: state_next = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
        if (flush) state_next = LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            bias_q    <= 16'h0;
            res_data  <= 16'h0;
            res_count <= '0;
        end else if (flush) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            case (state)
                LOAD: begin
                    idx <= '0;
                    if (ld_hs)   cnt    <= cnt + CW'(1);
                    if (last_hs) bias_q <= ld_bias;
                end
                RUN:   idx <= idx + IW'(1);
                DRAIN: begin
                    idx       <= '0;
                    res_data  <= pe_out_psum;
                    res_count <= cnt;
                end
                DONE:  if (res_ready) cnt <= '0;
                default: ;
            endcase
        end
    end

    // Buffer is never cleared; only entries below cnt are ever read.
    always_ff @(posedge clk) begin
        if (!rst && !flush && state == LOAD && ld_valid) begin
            ifmap_buf[cnt[IW-1:0]]  <= ld_ifmap;
            filter_buf[cnt[IW-1:0]] <= ld_filter;
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: behavioural PE attached, scoreboard of expected
// dot products pushed at load time and popped at the result handshake.

module tb_pe_feeder;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst, flush;
    logic            ld_valid, ld_ready, ld_last;
    logic [15:0]     ld_ifmap, ld_filter, ld_bias;
    logic            pe_en;
    logic [15:0]     pe_ifmap, pe_filter, pe_psum, pe_out_psum;
    logic            res_valid, res_ready;
    logic [15:0]     res_data;
    logic [CW-1:0]   res_count;

    typedef struct packed {
        logic [15:0]   data;
        logic [CW-1:0] count;
    } res_t;

    res_t        sb[$];
    logic [15:0] ja [64];
    logic [15:0] jb [64];
    logic [15:0] pe_acc = 16'h0;
    int          checks = 0;
    int          errors = 0;

    pe_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ifmap(ld_ifmap),
        .ld_filter(ld_filter), .ld_last(ld_last), .ld_bias(ld_bias),
        .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_filter(pe_filter),
        .pe_psum(pe_psum), .pe_out_psum(pe_out_psum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_count(res_count)
    );

    always #5 clk = ~clk;

    // Behavioural PE: registered lower-16-bit multiply-accumulate.
    always @(posedge clk) if (pe_en) pe_acc <= 16'(pe_psum + pe_ifmap * pe_filter);
    assign pe_out_psum = pe_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_job(input int n, input logic [15:0] bias, input bit use_last, input bit push);
        logic [15:0] sum;
        res_t        r;
        sum = bias;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ld_ready_load", ld_ready, 1);
            ld_valid  = 1'b1;
            ld_ifmap  = ja[i];
            ld_filter = jb[i];
            ld_last   = use_last && (i == n - 1);
            ld_bias   = (i == n - 1) ? bias : 16'($urandom);
            sum       = 16'(sum + ja[i] * jb[i]);
            @(posedge clk);
        end
        if (push) begin
            r.data  = sum;
            r.count = CW'(n);
            sb.push_back(r);
        end
    endtask

    // Called right after the accepting edge E; negedge j follows edge E+j.
    task automatic finish_job(input int n, input int hold);
        int   j, en_cnt, busy_bad;
        bit   seen;
        res_t r;
        en_cnt = 0; busy_bad = 0; seen = 0;
        for (j = 0; j < 200; j++) begin
            @(negedge clk);
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            if (ld_ready) busy_bad++;
            if (res_valid) begin
                seen = 1;
                break;
            end
            if (pe_en) en_cnt++;
        end
        check("res_seen", seen, 1);
        check("res_latency", j, n + 1);
        check("pe_en_cycles", en_cnt, n);
        check("ld_ready_busy", busy_bad, 0);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        r = sb.pop_front();
        check("res_data", res_data, r.data);
        check("res_count", res_count, r.count);
        for (int h = 0; h < hold; h++) begin
            ld_valid = 1'b1;
            ld_last  = 1'b1;
            ld_ifmap = 16'($urandom);
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, r.data);
            check("hold_count", res_count, r.count);
            check("hold_ld_ready", ld_ready, 0);
        end
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_ld_ready", ld_ready, 1);
        check("post_res_valid", res_valid, 0);
    endtask

    task automatic abort_job(input bit use_rst);
        int bad;
        ja[0] = 16'd1; jb[0] = 16'd2; ja[1] = 16'd3; jb[1] = 16'd4;
        ja[2] = 16'd5; jb[2] = 16'd6; ja[3] = 16'd7; jb[3] = 16'd8;
        send_job(4, 16'd9, 1, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        check("abort_in_run", pe_en, 1);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        check("abort_pe_en", pe_en, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_ld_ready", ld_ready, 1);
        if (use_rst) begin
            check("rst_res_data", res_data, 0);
            check("rst_res_count", res_count, 0);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (res_valid || pe_en || !ld_ready) bad++;
        end
        check("abort_quiet", bad, 0);
        ja[0] = 16'd3; jb[0] = 16'd3;
        send_job(1, 16'd1, 1, 1);
        finish_job(1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        ld_ifmap = 16'h0; ld_filter = 16'h0; ld_bias = 16'h0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_pe_en", pe_en, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_count", res_count, 0);
        check("rst_pe_psum", pe_psum, 0);
        rst = 1'b0;

        // Basic: 10 + 2*3 + 4*5 + 1*7 = 43
        ja[0] = 16'd2; jb[0] = 16'd3; ja[1] = 16'd4; jb[1] = 16'd5; ja[2] = 16'd1; jb[2] = 16'd7;
        send_job(3, 16'd10, 1, 1);
        finish_job(3, 0);

        // Wrap-around: 0x0100*0x0100 vanishes mod 2^16; with 10-cycle backpressure
        ja[0] = 16'h0100; jb[0] = 16'h0100;
        send_job(1, 16'h0005, 1, 1);
        finish_job(1, 10);

        // Forced last at DEPTH pairs
        for (int i = 0; i < DEPTH; i++) begin
            ja[i] = 16'd1; jb[i] = 16'd1;
        end
        send_job(DEPTH, 16'd0, 0, 1);
        finish_job(DEPTH, 0);

        // Mixed values with product overflow
        for (int i = 0; i < 5; i++) begin
            ja[i] = 16'($urandom); jb[i] = 16'($urandom);
        end
        send_job(5, 16'hfff0, 1, 1);
        finish_job(5, 3);

        abort_job(0);
        abort_job(1);

        // Flush together with an ld_last handshake discards the partial job
        ja[0] = 16'd7; jb[0] = 16'd7; ja[1] = 16'd9; jb[1] = 16'd9;
        send_job(2, 16'd0, 0, 0);
        @(negedge clk);
        ld_valid = 1'b1; ld_last = 1'b1; ld_ifmap = 16'd5; ld_filter = 16'd5; ld_bias = 16'd50;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        check("flush_ld_ready", ld_ready, 1);
        check("flush_pe_en", pe_en, 0);
        ja[0] = 16'd2; jb[0] = 16'd2;
        send_job(1, 16'd0, 1, 1);
        finish_job(1, 0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
